// File: rtl/bit_deser_pkg.sv
// bit_deser_pkg: shared state type and counter sizing helper for the bit deserializer.
package bit_deser_pkg;
    typedef enum logic {HUNT, COLLECT} deser_state_t;
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/word_fifo2.sv
// word_fifo2: 2-entry FIFO of {tag, data}; head is zero when empty.
module word_fifo2 #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    logic [1:0]    cnt_q, cnt_d, pc;
    logic [DW-1:0] m0_q, m0_d, m1_q, m1_d, p0, p1;
    logic          do_pop, do_push;
    // Pop first, then push into the first free slot, so full+pop+push is accepted.
    always_comb begin
        do_pop  = pop && (cnt_q != 2'd0);
        pc      = cnt_q - {1'b0, do_pop};
        do_push = push && (pc != 2'd2);
        p0      = do_pop ? m1_q : m0_q;
        p1      = do_pop ? '0 : m1_q;
        m0_d    = (do_push && pc == 2'd0) ? push_data : p0;
        m1_d    = (do_push && pc == 2'd1) ? push_data : p1;
        cnt_d   = pc + {1'b0, do_push};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            m0_q  <= '0;
            m1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            m0_q  <= m0_d;
            m1_q  <= m1_d;
        end
    end
    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);
    assign head  = empty ? '0 : m0_q;
endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer: hunts a bit-aligned SYNC word, then assembles FRAME_WORDS words
// into a 2-entry valid/ready output buffer with a sticky overflow flag.
module bit_deserializer
    import bit_deser_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
    parameter int               FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic [WIDTH-1:0] word_out,
    output logic             word_vld,
    input  logic             word_rdy,
    output logic             frame_start,
    output logic             locked,
    output logic             overflow
);
    localparam int BW = cnt_bits(WIDTH);
    localparam int WW = $clog2(FRAME_WORDS) + 1;
    localparam int FW = cnt_bits(WIDTH + 1);
    deser_state_t   state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_nxt;
    logic [FW-1:0]  fill_q, fill_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]  word_cnt_q, word_cnt_d;
    logic           ovf_q, ovf_d, push, pop, full, empty;
    logic [WIDTH:0] head;
    // fill guards against reset zeros (or stale payload bits) matching SYNC.
    always_comb begin
        sr_nxt     = {sr_q[WIDTH-2:0], bit_in};
        state_d    = state_q;
        sr_d       = sr_q;
        fill_d     = fill_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        push       = 1'b0;
        if (bit_vld) begin
            sr_d = sr_nxt;
            if (state_q == HUNT) begin
                fill_d = (fill_q == FW'(WIDTH)) ? fill_q : fill_q + 1'b1;
                if (fill_q >= FW'(WIDTH - 1) && sr_nxt == SYNC) begin
                    state_d    = COLLECT;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end else if (bit_cnt_q == BW'(WIDTH - 1)) begin
                push       = 1'b1;
                bit_cnt_d  = '0;
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q == WW'(FRAME_WORDS - 1)) begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        ovf_d = ovf_q | (push & full & ~pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            fill_q     <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            fill_q     <= fill_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
        end
    end
    word_fifo2 #(.DW(WIDTH + 1)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({word_cnt_q == '0, sr_nxt}),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );
    assign pop         = word_vld & word_rdy;
    assign word_vld    = ~empty;
    assign word_out    = head[WIDTH-1:0];
    assign frame_start = head[WIDTH];
    assign locked      = (state_q == COLLECT);
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: bit-position reference model compared every cycle, plus literal frame checks.
module tb_bit_deserializer;
    localparam int         W      = 8;
    localparam logic [7:0] SYNC   = 8'hA5;
    localparam int         FWORDS = 4;
    logic       clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_vld = 1'b0, word_rdy = 1'b1;
    logic [7:0] word_out;
    logic       word_vld, frame_start, locked, overflow;
    int         checks = 0, errors = 0;
    bit         bits[$];
    logic [8:0] mq[$], dlog[$], exp_q[$];
    int         lock_pos = -1, hunt_from = 0;
    logic       m_ovf = 1'b0;

    bit_deserializer #(.WIDTH(W), .SYNC(SYNC), .FRAME_WORDS(FWORDS)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
        .word_out(word_out), .word_vld(word_vld), .word_rdy(word_rdy),
        .frame_start(frame_start), .locked(locked), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] last_word(input int n);
        logic [7:0] v = '0;
        for (int i = n - W + 1; i <= n; i++) v = {v[6:0], bits[i]};
        return v;
    endfunction

    // Model: positions in the stream of valid bits since reset decide lock and word boundaries.
    task automatic model_step();
        int n, k;
        logic popping, pushing;
        logic [8:0] pent;
        if (rst) begin
            bits.delete();
            mq.delete();
            lock_pos  = -1;
            hunt_from = 0;
            m_ovf     = 1'b0;
            return;
        end
        popping = (mq.size() > 0) && word_rdy;
        pushing = 1'b0;
        pent    = '0;
        if (bit_vld) begin
            bits.push_back(bit_in);
            n = bits.size() - 1;
            if (lock_pos < 0) begin
                if (n - hunt_from + 1 >= W && last_word(n) == SYNC) lock_pos = n + 1;
            end else begin
                k = n - lock_pos + 1;
                if (k % W == 0) begin
                    pushing = 1'b1;
                    pent    = {k / W == 1, last_word(n)};
                    if (k / W == FWORDS) begin
                        lock_pos  = -1;
                        hunt_from = n + 1;
                    end
                end
            end
        end
        if (popping) void'(mq.pop_front());
        if (pushing) begin
            if (mq.size() < 2) mq.push_back(pent);
            else m_ovf = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("word_vld", word_vld, mq.size() > 0);
        chk("word_out", word_out, mq.size() > 0 ? mq[0][7:0] : 8'h0);
        chk("frame_start", frame_start, mq.size() > 0 ? mq[0][8] : 1'b0);
        chk("locked", locked, lock_pos >= 0);
        chk("overflow", overflow, m_ovf);
        if (word_vld && word_rdy) dlog.push_back({frame_start, word_out});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int maxgap);
        bit_vld = 1'b0;
        repeat ($urandom_range(0, maxgap)) tick();
        bit_in  = b;
        bit_vld = 1'b1;
        tick();
        bit_vld = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int maxgap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], maxgap);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bit_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        dlog.delete();
    endtask

    task automatic set_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        exp_q.delete();
        exp_q.push_back({1'b1, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b0, c});
        exp_q.push_back({1'b0, d});
    endtask

    task automatic chk_log();
        chk("log_len", dlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dlog.size(); i++) chk("log_word", dlog[i], exp_q[i]);
    endtask

    initial begin
        logic [15:0] pre;
        logic [7:0]  cur;
        int          bi;
        // 1: reset
        tick();
        tick();
        chk("rst_word_vld", word_vld, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_word_out", word_out, 8'h0);
        rst = 1'b0;
        dlog.delete();
        // 2: aligned frame
        send_byte(8'hA5, 0);
        chk("t2_locked", locked, 1'b1);
        send_byte(8'h12, 0);
        chk("t2_vld12", word_vld, 1'b1);
        chk("t2_word12", word_out, 8'h12);
        chk("t2_fs12", frame_start, 1'b1);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        chk("t2_word78", word_out, 8'h78);
        chk("t2_fs78", frame_start, 1'b0);
        chk("t2_unlock", locked, 1'b0);
        repeat (3) tick();
        set_exp(8'h12, 8'h34, 8'h56, 8'h78);
        chk_log();
        // 3: unaligned sync
        do_reset();
        pre = 16'h0A5F;
        for (int i = 15; i >= 0; i--) begin
            send_bit(pre[i], 0);
            if (i == 5) chk("t3_nolock11", locked, 1'b0);
            if (i == 4) chk("t3_lock12", locked, 1'b1);
        end
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        repeat (3) tick();
        set_exp(8'hF1, 8'h23, 8'h45, 8'h67);
        chk_log();
        // 4: consumer stalled, overflow
        do_reset();
        word_rdy = 1'b0;
        send_byte(8'hA5, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_head", word_out, 8'h12);
        chk("t4_head_fs", frame_start, 1'b1);
        word_rdy = 1'b1;
        repeat (4) tick();
        exp_q.delete();
        exp_q.push_back({1'b1, 8'h12});
        exp_q.push_back({1'b0, 8'h34});
        chk_log();
        chk("t4_sticky", overflow, 1'b1);
        chk("t4_empty", word_vld, 1'b0);
        // 5: gaps in bit_vld
        do_reset();
        send_byte(8'hA5, 3);
        send_byte(8'h12, 3);
        send_byte(8'h34, 3);
        send_byte(8'h56, 3);
        send_byte(8'h78, 3);
        repeat (3) tick();
        set_exp(8'h12, 8'h34, 8'h56, 8'h78);
        chk_log();
        // 6: reset mid-frame then a clean frame
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h12, 0);
        for (int i = 7; i >= 4; i--) send_bit(1'((8'h34 >> i) & 8'h1), 0);
        rst = 1'b1;
        tick();
        chk("t6_vld", word_vld, 1'b0);
        chk("t6_locked", locked, 1'b0);
        rst = 1'b0;
        dlog.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h9A, 0);
        send_byte(8'hBC, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hF0, 0);
        repeat (3) tick();
        set_exp(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        chk_log();
        // 7: random traffic against the model
        do_reset();
        cur = SYNC;
        bi  = 7;
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 399) == 0);
            word_rdy = ($urandom_range(0, 3) != 0);
            bit_vld  = ($urandom_range(0, 3) != 0);
            bit_in   = cur[bi];
            if (bit_vld) begin
                if (bi == 0) begin
                    bi  = 7;
                    cur = ($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom);
                end else begin
                    bi--;
                end
            end
            tick();
        end
        rst      = 1'b0;
        bit_vld  = 1'b0;
        word_rdy = 1'b1;
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
